// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule constants, state encoding and word helpers
// used by the iterative key-schedule sequencer.
package aes_key_pkg;

   localparam int unsigned NUM_ROUNDS = 10;

   localparam logic [7:0] RCON [NUM_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } ks_state_e;

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Byte 0 sits in the most significant byte, so the left rotate moves it to the bottom.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/key_expand_round.sv
// One combinational AES-128 key-expansion step: derives round key N from
// round key N-1 using the round constant selected by rcon_index (1..10).
module key_expand_round
   import aes_key_pkg::*;
(
   input  logic [127:0] prev_key,
   input  logic [3:0]   rcon_index,
   output logic [127:0] next_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] n0, n1, n2, n3;
   logic [7:0]  rcon;

   always_comb begin
      rcon = '0;
      if (rcon_index >= 4'd1 && rcon_index <= 4'd10) begin
         rcon = RCON[rcon_index - 4'd1];
      end
   end

   assign w0 = prev_key[127:96];
   assign w1 = prev_key[95:64];
   assign w2 = prev_key[63:32];
   assign w3 = prev_key[31:0];

   assign n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one shared expansion step run over
// ten cycles, 11-entry round-key file and a registered read port.
module key_schedule_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned KEY_W      = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_load,
   output logic             busy,
   output logic             done,
   output logic             keys_valid,
   input  logic [3:0]       rd_round,
   output logic [KEY_W-1:0] rd_key,
   output logic             rd_valid
);
   import aes_key_pkg::*;

   if (NUM_ROUNDS != aes_key_pkg::NUM_ROUNDS || KEY_W != 128) begin : g_bad_config
      $error("key_schedule_ctrl supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
   end

   localparam logic [3:0] LAST_CNT = 4'(aes_key_pkg::NUM_ROUNDS);

   ks_state_e        state, state_nx;
   logic [3:0]       round_cnt, round_cnt_nx;
   logic             done_nx;
   logic [KEY_W-1:0] rk [0:10];
   logic [KEY_W-1:0] prev_key, next_key;
   logic             rd_gen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         round_cnt <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         round_cnt <= round_cnt_nx;
         done      <= done_nx;
      end
   end

   // A load wins over an in-flight expansion; round_cnt parks at 10 in READY.
   always_comb begin
      state_nx     = state;
      round_cnt_nx = round_cnt;
      done_nx      = 1'b0;
      if (key_load) begin
         state_nx     = EXPAND;
         round_cnt_nx = 4'd1;
      end else if (state == EXPAND) begin
         if (round_cnt == LAST_CNT) begin
            state_nx = READY;
            done_nx  = 1'b1;
         end else begin
            round_cnt_nx = round_cnt + 4'd1;
         end
      end
   end

   assign busy       = (state == EXPAND);
   assign keys_valid = (state == READY);

   always_comb begin
      prev_key = '0;
      if (round_cnt != 4'd0) begin
         prev_key = rk[round_cnt - 4'd1];
      end
   end

   key_expand_round u_expand (
      .prev_key   (prev_key),
      .rcon_index (round_cnt),
      .next_key   (next_key)
   );

   // Keys below round_cnt are already written while expanding; all are in READY.
   assign rd_gen = ((state == EXPAND) && (rd_round < round_cnt)) ||
                   ((state == READY)  && (rd_round <= LAST_CNT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 11; i++) begin
            rk[i] <= '0;
         end
         rd_key   <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (key_load) begin
            rk[0] <= key_in;
         end else if (state == EXPAND) begin
            rk[round_cnt] <= next_key;
         end
         rd_valid <= rd_gen;
         rd_key   <= rd_gen ? rk[rd_round] : '0;
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: FIPS-197 vectors plus random keys
// checked against a key-expansion model built from GF(2^8) arithmetic.
module tb_key_schedule_ctrl;

   typedef logic [127:0] rk_t [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk;
   logic         reset;
   logic [127:0] key_in;
   logic         key_load;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic         rd_valid;

   int unsigned  total;
   int unsigned  bad;
   logic [7:0]   sb [256];

   key_schedule_ctrl #(
      .NUM_ROUNDS (10),
      .KEY_W      (128)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_in     (key_in),
      .key_load   (key_load),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rd_round   (rd_round),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from first principles: inverse is a^254, then the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] b;
      logic [7:0] s;
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, a);
      s = b ^ 8'h63;
      for (int n = 1; n <= 4; n++) s = s ^ ((b << n) | (b >> (8 - n)));
      return s;
   endfunction

   task automatic ref_expand(input logic [127:0] key, output rk_t keys);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenario tasks ----------------
   // Loads k, then over the ten expansion edges checks status and random reads:
   // a read sampled at the e-th edge after the load sees keys 0..e-1 only.
   task automatic load_and_track(input logic [127:0] k, input rk_t ref_keys, input string tag);
      int          r;
      logic        exp_v;
      logic [127:0] exp_k;
      key_in   = k;
      key_load = 1'b1;
      rd_round = 4'd15;
      step();
      key_load = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         total++;
         if ({busy, keys_valid, done} !== 3'b100) begin
            bad++;
            $display("FAIL %s status e=%0d: busy/kv/done got %b want 100", tag, e, {busy, keys_valid, done});
         end
         r = $urandom_range(15, 0);
         rd_round = 4'(r);
         step();
         exp_v = (r < e) && (r <= 10);
         exp_k = '0;
         if (exp_v) exp_k = ref_keys[r];
         total++;
         if ({rd_valid, rd_key} !== {exp_v, exp_k}) begin
            bad++;
            $display("FAIL %s early_read e=%0d r=%0d: got v=%b %h want v=%b %h", tag, e, r, rd_valid, rd_key, exp_v, exp_k);
         end
      end
      total++;
      if ({busy, keys_valid, done} !== 3'b011) begin
         bad++;
         $display("FAIL %s finish: busy/kv/done got %b want 011", tag, {busy, keys_valid, done});
      end
   endtask

   task automatic read_all(input rk_t ref_keys, input string tag);
      for (int r = 0; r <= 10; r++) begin
         rd_round = 4'(r);
         step();
         total++;
         if ({rd_valid, rd_key, keys_valid} !== {1'b1, ref_keys[r], 1'b1}) begin
            bad++;
            $display("FAIL %s read r=%0d: got v=%b %h kv=%b want v=1 %h kv=1", tag, r, rd_valid, rd_key, keys_valid, ref_keys[r]);
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      key_load = 1'b0;
      key_in   = '0;
      rd_round = 4'd0;
      step();
      step();
      total++;
      if ({busy, done, keys_valid, rd_valid, rd_key} !== '0) begin
         bad++;
         $display("FAIL reset_state: busy/done/kv/rv got %b rd_key %h want all 0", {busy, done, keys_valid, rd_valid}, rd_key);
      end
      reset = 1'b0;
      step();
      step();
      total++;
      if ({busy, done, keys_valid, rd_valid} !== 4'b0000) begin
         bad++;
         $display("FAIL idle_hold: busy/done/kv/rv got %b want 0000", {busy, done, keys_valid, rd_valid});
      end
   endtask

   task automatic test_fips();
      rk_t ref_keys;
      ref_expand(FIPS_KEY, ref_keys);
      load_and_track(FIPS_KEY, ref_keys, "fips");
      rd_round = 4'd1;
      step();
      total++;
      if ({done, rd_valid, rd_key} !== {1'b0, 1'b1, FIPS_RK1}) begin
         bad++;
         $display("FAIL fips_rk1: got done=%b v=%b %h want done=0 v=1 %h", done, rd_valid, rd_key, FIPS_RK1);
      end
      rd_round = 4'd10;
      step();
      total++;
      if ({rd_valid, rd_key} !== {1'b1, FIPS_RK10}) begin
         bad++;
         $display("FAIL fips_rk10: got v=%b %h want v=1 %h", rd_valid, rd_key, FIPS_RK10);
      end
      read_all(ref_keys, "fips");
   endtask

   task automatic test_early_read();
      logic         exp_v;
      logic [127:0] exp_k;
      reset = 1'b1;
      #2;
      reset    = 1'b0;
      rd_round = 4'd3;
      key_in   = FIPS_KEY;
      key_load = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         step();
         key_load = 1'b0;
         exp_v = (i >= 4);
         exp_k = exp_v ? FIPS_RK3 : '0;
         total++;
         if ({rd_valid, rd_key} !== {exp_v, exp_k}) begin
            bad++;
            $display("FAIL early_rk3 edge=%0d: got v=%b %h want v=%b %h", i, rd_valid, rd_key, exp_v, exp_k);
         end
      end
   endtask

   task automatic test_abort();
      rk_t ref_keys;
      ref_expand(FIPS_KEY, ref_keys);
      key_in   = '0;
      key_load = 1'b1;
      rd_round = 4'd15;
      step();
      key_load = 1'b0;
      for (int j = 0; j < 4; j++) begin
         total++;
         if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL abort_zero cyc=%0d: busy/done got %b want 10", j, {busy, done});
         end
         if (j < 3) step();
      end
      load_and_track(FIPS_KEY, ref_keys, "abort");
      rd_round = 4'd10;
      step();
      total++;
      if ({rd_valid, rd_key} !== {1'b1, FIPS_RK10}) begin
         bad++;
         $display("FAIL abort_rk10: got v=%b %h want v=1 %h", rd_valid, rd_key, FIPS_RK10);
      end
   endtask

   task automatic test_zero_key();
      rk_t ref_keys;
      ref_expand('0, ref_keys);
      load_and_track('0, ref_keys, "zero");
      rd_round = 4'd10;
      step();
      total++;
      if ({rd_valid, rd_key} !== {1'b1, ZERO_RK10}) begin
         bad++;
         $display("FAIL zero_rk10: got v=%b %h want v=1 %h", rd_valid, rd_key, ZERO_RK10);
      end
      read_all(ref_keys, "zero");
   endtask

   task automatic test_reset_mid();
      rk_t          ref_keys;
      logic [127:0] k;
      k = rand_key();
      key_in   = k;
      key_load = 1'b1;
      rd_round = 4'd0;
      step();
      key_load = 1'b0;
      for (int j = 0; j < 5; j++) step();
      total++;
      if ({busy, rd_valid} !== 2'b11) begin
         bad++;
         $display("FAIL pre_reset: busy/rv got %b want 11", {busy, rd_valid});
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({busy, done, keys_valid, rd_valid, rd_key} !== '0) begin
         bad++;
         $display("FAIL async_reset: busy/done/kv/rv got %b rd_key %h want all 0", {busy, done, keys_valid, rd_valid}, rd_key);
      end
      step();
      reset = 1'b0;
      k = rand_key();
      ref_expand(k, ref_keys);
      load_and_track(k, ref_keys, "after_reset");
      read_all(ref_keys, "after_reset");
   endtask

   task automatic test_out_of_range();
      rk_t          ref_keys;
      logic [127:0] k;
      logic [3:0]   rr [5];
      rr = '{4'd11, 4'd15, 4'd12, 4'd13, 4'd14};
      for (int j = 0; j < 5; j++) begin
         rd_round = rr[j];
         step();
         total++;
         if ({rd_valid, rd_key} !== '0) begin
            bad++;
            $display("FAIL out_of_range r=%0d: got v=%b %h want v=0 0", rr[j], rd_valid, rd_key);
         end
      end
      k = rand_key();
      ref_expand(k, ref_keys);
      load_and_track(k, ref_keys, "reload");
      read_all(ref_keys, "reload");
   endtask

   task automatic test_back_to_back();
      rk_t          ref_keys;
      logic [127:0] k;
      for (int n = 0; n < 6; n++) begin
         k = rand_key();
         ref_expand(k, ref_keys);
         load_and_track(k, ref_keys, "b2b");
      end
      read_all(ref_keys, "b2b");
   endtask

   task automatic test_random();
      rk_t          ref_keys;
      logic [127:0] k;
      for (int n = 0; n < 4; n++) begin
         k = rand_key();
         ref_expand(k, ref_keys);
         load_and_track(k, ref_keys, "random");
         read_all(ref_keys, "random");
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      test_reset();
      test_fips();
      test_early_read();
      test_abort();
      test_zero_key();
      test_reset_mid();
      test_out_of_range();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
